// File: rtl/mfp_pmod_als_ctrl.sv
// PMOD ALS light-sensor reader: CS/SCK sequencing, 16-bit frame capture, 8-bit result.
// Optional 4-sample running average when MFP_PMOD_ALS_AVERAGE_EN is defined.
module mfp_pmod_als_ctrl #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned CS_SETUP      = 2,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto_en,
    output logic       busy,
    output logic       valid,
    output logic [7:0] value,
    output logic [7:0] raw_value,
    output logic       spi_cs,
    output logic       spi_sck,
    input  logic       spi_sdo
);

    typedef enum logic [2:0] {IDLE, WAKE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int unsigned CNT_MAX = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned TW      = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] PER_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_PERIOD - 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [3:0]      bit_cnt, bit_next;
    logic [TW-1:0]   tcnt;
    logic            tick;
    logic            pending;
    logic            leave_idle;
    logic            sample;
    logic            load;
    logic            cs_next, sck_next;
    // Bit 15 of the frame is always shifted out before use, so only 15 bits are kept.
    logic [14:0]     shreg;
    logic [7:0]      frame_value;

    assign tick        = auto_en && (tcnt == TICK_LAST);
    assign leave_idle  = (state == IDLE) && pending;
    assign sample      = (state == SHIFT) && (cnt == HALF_LAST);
    assign load        = (state == HOLD) && (state_next == DONE);
    assign frame_value = shreg[11:4];
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        bit_next   = bit_cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (pending) state_next = WAKE;
            end
            WAKE:  if (cnt == PER_LAST) state_next = SETUP;
            SETUP: if (cnt == SETUP_LAST) state_next = SHIFT;
            SHIFT: begin
                if (cnt == PER_LAST) begin
                    cnt_next = '0;
                    bit_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) state_next = HOLD;
                end
            end
            HOLD:  if (cnt == PER_LAST) state_next = DONE;
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) cnt_next = '0;

        // SCK and CS are registered from the next-state view so the pins never glitch.
        sck_next = 1'b1;
        if ((state_next == WAKE || state_next == SHIFT) && cnt_next < HALF) sck_next = 1'b0;
        cs_next = !(state_next == SETUP || state_next == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            pending   <= 1'b0;
            shreg     <= '0;
            spi_cs    <= 1'b1;
            spi_sck   <= 1'b1;
            valid     <= 1'b0;
            raw_value <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            spi_cs  <= cs_next;
            spi_sck <= sck_next;
            valid   <= load;

            if (!auto_en || tick) tcnt <= '0;
            else                  tcnt <= tcnt + TW'(1);

            // Clearing on IDLE exit wins; otherwise one request is held.
            if (leave_idle) pending <= 1'b0;
            else            pending <= pending | start | tick;

            if (sample) shreg <= {shreg[13:0], spi_sdo};
            if (load)   raw_value <= frame_value;
        end
    end

`ifdef MFP_PMOD_ALS_AVERAGE_EN
    logic [7:0] hist [4];
    logic [9:0] sum, new_sum;

    assign new_sum = sum - {2'b00, hist[3]} + {2'b00, frame_value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
            sum   <= '0;
            value <= '0;
        end else if (load) begin
            hist[0] <= frame_value;
            for (int unsigned i = 1; i < 4; i++) hist[i] <= hist[i-1];
            sum   <= new_sum;
            value <= new_sum[9:2];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    value <= '0;
        else if (load) value <= frame_value;
    end
`endif

endmodule

// File: tb/tb_mfp_pmod_als_ctrl.sv
// Directed bench for mfp_pmod_als_ctrl with an inline sensor stub (value 8'hAB) and scoreboard.
// Define MFP_PMOD_ALS_AVERAGE_EN to exercise the averaging build.
module tb_mfp_pmod_als_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic       busy, valid, spi_cs, spi_sck, spi_sdo;
    logic [7:0] value, raw_value;

    mfp_pmod_als_ctrl #(.SAMPLE_PERIOD(200)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
        .busy(busy), .valid(valid), .value(value), .raw_value(raw_value),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_sdo(spi_sdo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sensor stub: 3 lead zeros, 8 data bits, 4 trail zeros; next bit presented after each rise.
    logic [15:0] frame = 16'h0AB0;
    int unsigned k = 0;
    always @(negedge spi_cs) k = 0;
    always @(posedge spi_sck) if (!spi_cs) k++;
    assign spi_sdo = (k < 16) ? frame[4'(15 - k)] : 1'b0;

    // Scoreboard entries: {value, raw_value}.
    logic [15:0] sbq [$];
    int unsigned vtimes [$];
    int unsigned nvalid = 0;
    logic        busy_at_valid = 1'b0;
    int unsigned hcnt = 0;

    task automatic push_exp();
        logic [7:0] v;
`ifdef MFP_PMOD_ALS_AVERAGE_EN
        int unsigned n;
        n = (hcnt + 1 > 4) ? 4 : hcnt + 1;
        hcnt = n;
        v = 8'((171 * n) >> 2);
`else
        v = 8'hAB;
`endif
        sbq.push_back({v, 8'hAB});
    endtask

    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b1;
    int unsigned rises = 0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (spi_sck !== prev_sck) check("sck_toggle_busy", busy, 1);
            if (prev_cs && !spi_cs) check("cs_fall_sck_high", spi_sck, 1);
            if (spi_sck && !prev_sck && !spi_cs) rises++;
            if (!prev_cs && spi_cs) begin
                check("sck_rises_per_frame", rises, 16);
                rises = 0;
            end
            if (valid === 1'b1) begin
                nvalid++;
                vtimes.push_back(cyc);
                busy_at_valid = busy;
                check("sb_not_empty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("value", value, e[15:8]);
                    check("raw_value", raw_value, e[7:0]);
                end
            end
        end else begin
            rises = 0;
        end
        prev_cs  = spi_cs;
        prev_sck = spi_sck;
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_nvalid(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned i = 0;
        while (nvalid < n && i < budget) begin
            step(1);
            i++;
        end
        check({tag, "_timeout"}, nvalid >= n, 1);
    endtask

    int unsigned c;
    logic [7:0] avg_tab [5];

    initial begin
        // Reset state
        #23;
        check("rst_cs", spi_cs, 1);
        check("rst_sck", spi_sck, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_value", value, 0);
        check("rst_raw", raw_value, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Single start: latency and busy drop
        c = cyc;
        push_exp();
        pulse_start();
        wait_nvalid(1, 300, "single");
        if (vtimes.size() >= 1) check("single_latency", vtimes[0], c + 148);
        check("busy_at_valid", busy_at_valid, 1);
        check("busy_after_valid", busy, 0);
        check("single_sb_empty", sbq.size(), 0);

        // Start held 3 clks plus a pulse mid-SHIFT: exactly two frames
        c = cyc;
        push_exp();
        push_exp();
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(60);
        pulse_start();
        wait_nvalid(3, 500, "queued");
        if (vtimes.size() >= 3) begin
            check("queued_first", vtimes[1], c + 148);
            check("queued_second", vtimes[2], c + 296);
        end
        step(300);
        check("queued_count", nvalid, 3);
        check("queued_sb_empty", sbq.size(), 0);

        // Auto sampling every 200 clks
        c = cyc;
        for (int i = 0; i < 5; i++) push_exp();
        auto_en = 1'b1;
        wait_nvalid(8, 1300, "auto");
        auto_en = 1'b0;
        if (vtimes.size() >= 8) begin
            check("auto_first", vtimes[3], c + 347);
            for (int i = 4; i < 8; i++) check("auto_spacing", vtimes[i] - vtimes[i-1], 200);
        end
        step(400);
        check("auto_count", nvalid, 8);
        check("auto_sb_empty", sbq.size(), 0);

        // Asynchronous reset mid-SHIFT
        push_exp();
        pulse_start();
        step(70);
        rst_n = 1'b0;
        #1;
        check("arst_cs", spi_cs, 1);
        check("arst_sck", spi_sck, 1);
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_value", value, 0);
        check("arst_raw", raw_value, 0);
        sbq.delete();
        hcnt = 0;
        step(2);
        rst_n = 1'b1;
        step(1);
        push_exp();
        pulse_start();
        wait_nvalid(9, 300, "after_rst");
        check("after_rst_count", nvalid, 9);
        check("after_rst_sb_empty", sbq.size(), 0);

`ifdef MFP_PMOD_ALS_AVERAGE_EN
        // Averaging ramp from a cleared history
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        avg_tab = '{8'h2A, 8'h55, 8'h80, 8'hAB, 8'hAB};
        for (int i = 0; i < 5; i++) begin
            sbq.push_back({avg_tab[i], 8'hAB});
            pulse_start();
            wait_nvalid(10 + i, 300, "avg");
        end
        check("avg_sb_empty", sbq.size(), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
